fib_arbiter: RTL

- Round-robin scheduler that shares one Fibonacci engine among NUM_REQ requesters.
- Accepts per-requester n values and launches the engine with a one-cycle strobe.
- Detects completion from the engine busy flag and returns the engine result to the owning requester over a valid/ready handshake.
- Sits between client blocks and the single engine instance; it is the only driver of the engine strobe and n inputs.

---
 rtl/fib_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin scheduler sharing one Fibonacci engine among
// NUM_REQ requesters. One job is in flight at a time. The result returns to
// the owning requester over a valid/ready handshake.
// Optional build macro FIB_ARB_TIMEOUT_EN adds a RUN-state watchdog with
// the o_eng_abort and o_rsp_err ports.
module fib_arbiter #(
  parameter int WIDTH          = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_n_bus,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  input  logic [NUM_REQ-1:0]       i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic                     o_idle,
  output logic                     o_eng_stb,
  output logic [WIDTH-1:0]         o_eng_n,
  input  logic                     i_eng_busy,
  input  logic [WIDTH-1:0]         i_eng_fib
`ifdef FIB_ARB_TIMEOUT_EN
  ,
  output logic                     o_eng_abort,
  output logic                     o_rsp_err
`endif
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_RUN,
    S_RESPOND
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   last_q;
  logic [IDXW-1:0]   owner_q;
  logic [IDXW-1:0]   winner_idx;
  logic              winner_found;
  logic [WIDTH-1:0]  winner_n;
  logic [NUM_REQ-1:0] owner_onehot;
  logic              launch_go;
  logic              run_done;
  logic              owner_ready;

  // Reject configurations the one-hot and pointer logic cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("fib_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  assign owner_onehot = NUM_REQ'(1) << owner_q;
  assign owner_ready  = i_rsp_ready[owner_q];
  assign launch_go    = (state_q == S_IDLE) && winner_found && !i_eng_busy;
  assign run_done     = (state_q == S_RUN) && !i_eng_busy;
  assign winner_n     = i_n_bus[int'(winner_idx)*WIDTH +: WIDTH];

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNTW-1:0] run_cnt_q;
  logic            timeout_hit;

  assign timeout_hit = (state_q == S_RUN) && i_eng_busy &&
                       (run_cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  // Watchdog: count RUN cycles from zero, pulse abort and flag the error.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_cnt_q   <= '0;
      o_eng_abort <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_eng_abort <= timeout_hit;
      if (state_q == S_WAIT_START) begin
        run_cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        run_cnt_q <= run_cnt_q + CNTW'(1);
      end
      if (run_done) begin
        o_rsp_err <= 1'b0;
      end else if (timeout_hit) begin
        o_rsp_err <= 1'b1;
      end
    end
  end
`endif

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin
    int k;
    winner_found = 1'b0;
    winner_idx   = '0;
    k            = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (!winner_found && i_req[IDXW'(k)]) begin
        winner_found = 1'b1;
        winner_idx   = IDXW'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (launch_go) state_d = S_LAUNCH;
      S_LAUNCH:     state_d = S_WAIT_START;
      S_WAIT_START: state_d = S_RUN;
      S_RUN: begin
        if (run_done) begin
          state_d = S_RESPOND;
        end
`ifdef FIB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_RESPOND;
        end
`endif
      end
      S_RESPOND:    if (owner_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    o_gnt       = '0;
    o_rsp_valid = '0;
    o_eng_stb   = 1'b0;
    o_idle      = 1'b0;
    case (state_q)
      S_IDLE:    o_idle = 1'b1;
      S_LAUNCH: begin
        o_eng_stb = 1'b1;
        o_gnt     = owner_onehot;
      end
      S_RESPOND: o_rsp_valid = owner_onehot;
      default:   ;
    endcase
  end

  // Job bookkeeping: owner and n latched at launch, result captured at completion.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q     <= IDXW'(NUM_REQ - 1);
      owner_q    <= '0;
      o_eng_n    <= '0;
      o_rsp_data <= '0;
    end else begin
      if (launch_go) begin
        owner_q <= winner_idx;
        o_eng_n <= winner_n;
      end
      if (run_done) begin
        o_rsp_data <= i_eng_fib;
      end
`ifdef FIB_ARB_TIMEOUT_EN
      else if (timeout_hit) begin
        o_rsp_data <= '0;
      end
`endif
      if (state_q == S_RESPOND && owner_ready) begin
        last_q <= owner_q;
      end
    end
  end

endmodule
